// File: rtl/instruction_encoder_loader.sv
// -----------------------------------------------------------------------------
// instruction_encoder_loader
//
// Packs instruction fields (opcode, funct, register indices, immediates) into
// 32-bit instruction words and streams them into instruction memory at
// sequential word addresses, one word per cycle. This is the inverse of the
// decode stage and sits between a boot/test loader and the imem write port.
//
// Field layout: opcode[31:27] rs[26:22] rt[21:17] rd[16:12] funct[3:0]
//               imm16[15:0] imm26[25:0]; every unused bit is written as 0.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              pulse: begin (or restart) a load session
//   in_valid/in_ready  field-set handshake, a beat moves when both are high
//   fmt                0=R, 1=I, 2=J, 3=illegal
//   opcode, funct,
//   rs, rt, rd,
//   imm, imm26         instruction fields (imm is signed, must fit 16 bits)
//   last               marks the final field-set of the session
//   mem_we/addr/wdata  registered instruction-memory write port
//   busy               session in progress (LOAD or DONE)
//   done               one-cycle pulse, coincides with the final write
//   count              words written in the current session
//   err_range          sticky: bad immediate or illegal fmt seen
//   err_full           sticky: DEPTH words written without a last beat
// -----------------------------------------------------------------------------
module instruction_encoder_loader #(
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [4:0]        opcode,
   input  logic [3:0]        funct,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [31:0]       imm,
   input  logic [25:0]       imm26,
   input  logic              last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              err_range,
   output logic              err_full
);

   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              err_range_q, err_range_d;
   logic              err_full_q, err_full_d;

   logic [31:0]       word_c;
   logic              bad_c;
   logic              imm_fits_c;
   logic              in_ready_c;
   logic              accept_c;
   logic [ADDR_W:0]   count_inc_c;

   // Encode the presented field-set and flag it if it cannot be encoded.
   // An immediate fits 16 signed bits exactly when bits 31..15 are all
   // copies of the sign, so they must be all zeros or all ones.
   always_comb begin
      word_c     = 32'h0;
      imm_fits_c = (imm[31:15] == '0) || (imm[31:15] == '1);
      bad_c      = 1'b0;
      unique case (fmt)
         2'd0: word_c = {opcode, rs, rt, rd, 8'b0, funct};
         2'd1: begin
            word_c = {opcode, rs, rt, 1'b0, imm[15:0]};
            bad_c  = !imm_fits_c;
         end
         2'd2: word_c = {opcode, 1'b0, imm26};
         default: bad_c = 1'b1;
      endcase
   end

   // Count already includes a write that is issuing this cycle, so the
   // DEPTH limit is a plain compare. A start in the same cycle wins over
   // any beat on the bus, so the beat is refused rather than half-taken.
   always_comb begin
      in_ready_c  = (state_q == S_LOAD) && !start && (count_q < DEPTH_C);
      accept_c    = in_valid && in_ready_c;
      count_inc_c = count_q + 1'b1;
   end

   // Next-state and write-port logic. A new write is only ever launched by
   // an accepted good beat; the previously registered write still drains
   // on its own, which is why start does not touch mem_we.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      count_d     = count_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_range_d = err_range_q;
      err_full_d  = err_full_q;

      if (start) begin
         state_d     = S_LOAD;
         ptr_d       = BASE_C;
         count_d     = '0;
         err_range_d = 1'b0;
         err_full_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_LOAD: begin
               if (accept_c) begin
                  if (bad_c) begin
                     err_range_d = 1'b1;
                     state_d     = S_ERR;
                  end else begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = ptr_q;
                     mem_wdata_d = word_c;
                     ptr_d       = ptr_q + 1'b1;
                     count_d     = count_inc_c;
                     // A last beat that also fills the session still
                     // counts as a clean finish.
                     if (last) begin
                        state_d = S_DONE;
                     end else if (count_inc_c == DEPTH_C) begin
                        state_d    = S_ERR;
                        err_full_d = 1'b1;
                     end
                  end
               end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR:  ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers; reset drops any in-flight write at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= BASE_C;
         count_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_C;
         mem_wdata_q <= 32'h0;
         err_range_q <= 1'b0;
         err_full_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_range_q <= err_range_d;
         err_full_q  <= err_full_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q == S_LOAD) || (state_q == S_DONE);
   assign done      = (state_q == S_DONE);
   assign count     = count_q;
   assign err_range = err_range_q;
   assign err_full  = err_full_q;

endmodule
